pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware call/return stack, the next-generation PC for the sequencer datapath. It adds configurable address width, a stall enable, subroutine CALL/RET backed by a LIFO of return addresses, and stack status/error flags on top of plain increment/jump. PC_OUT drives the instruction memory address; the decoder drives the command inputs.

## Interface
- ADDR_W, 5, width of PC and all addresses (≥2)
- DEPTH, 4, return-stack entries (≥1)
- RESET_ADDR, 0, PC value loaded on reset
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-low (RST=0 at a rising edge resets)
- EN  in  1  advance enable; 0 = stall, all state held, commands ignored
- JMP  in  1  load PC from JMP_ADDR
- CALL  in  1  push return address, load PC from JMP_ADDR
- RET  in  1  pop return address into PC
- JMP_ADDR  in  ADDR_W  jump/call target
- PC_OUT  out  ADDR_W  current program counter
- STACK_LVL  out  $clog2(DEPTH+1)  number of valid stack entries
- STACK_FULL  out  1  STACK_LVL == DEPTH
- STACK_EMPTY  out  1  STACK_LVL == 0
- STACK_ERR  out  1  sticky overflow/underflow flag

## Operation
- Reset (RST=0 at edge): PC_OUT=RESET_ADDR, STACK_LVL=0, STACK_EMPTY=1, STACK_FULL=0, STACK_ERR=0; stack contents don't-care. Reset overrides EN and all commands, including mid-CALL/RET sequences.
- With EN=1, one action per edge, priority CALL > RET > JMP > increment:
  - CALL, not full: push PC_OUT+1 (mod 2^ADDR_W), PC_OUT←JMP_ADDR, LVL+1.
  - CALL, full: overflow; no push, no jump, PC_OUT←PC_OUT+1, STACK_ERR←1.
  - RET, not empty: PC_OUT←top entry, LVL−1.
  - RET, empty: underflow; PC_OUT←PC_OUT+1, STACK_ERR←1.
  - JMP: PC_OUT←JMP_ADDR, stack unchanged.
  - none: PC_OUT←PC_OUT+1.
- Lower-priority commands asserted alongside a higher one are ignored entirely (e.g. CALL+RET = CALL only).
- Arithmetic: all increments modulo 2^ADDR_W; 2^ADDR_W−1 wraps to 0, including the pushed return address.
- STACK_ERR clears only on reset.
- EN=0: PC_OUT, stack, LVL and STACK_ERR held regardless of commands.

## Timing
- All outputs registered; an action sampled at edge N is visible on outputs after edge N (1-cycle latency, no combinational input→output path).
- STACK_FULL/STACK_EMPTY are decoded from the registered LVL and change in the same cycle as LVL.
- Back-to-back CALL/RET every cycle supported; a RET immediately after a CALL returns to the CALL address+1.
- Push and pop never occur in the same cycle.

## Structure
- Package pc_pkg: enum pc_action_t {PC_INC, PC_JMP, PC_CALL, PC_RET, PC_OVF, PC_UNF} for the resolved per-cycle action, used for priority decode and by bench coverage.
- Sub-module pc_lifo (params WIDTH, DEPTH): register-array LIFO with push/pop/level, full/empty; no error logic. pc_stack holds the PC register, priority decode and the sticky flag.

## Test plan
- Reset/increment: RESET_ADDR=3, release RST, EN=1, no commands for 4 cycles -> PC_OUT 3,4,5,6,7; hold RST=0 one cycle mid-count -> PC_OUT=3 next cycle.
- Wrap/stall: ADDR_W=5, run from 30 -> 31,0,1; drop EN for 3 cycles with JMP=1 -> PC_OUT and LVL frozen.
- Call/return: PC=4, CALL JMP_ADDR=20 -> PC=20, LVL=1; 2 increments -> 22; RET -> PC=5, LVL=0, STACK_EMPTY=1.
- Nested to full: DEPTH=4, four CALLs -> STACK_FULL=1; fifth CALL at PC=9 -> PC=10, STACK_ERR=1, LVL=4; four RETs pop return addresses in LIFO order.
- Underflow: after reset, RET at PC=0 -> PC=1, STACK_ERR=1, persists until reset.
- Priority: CALL+RET+JMP same edge at PC=7, JMP_ADDR=12 -> PC=12, LVL+1, top entry=8; RET+JMP with LVL=1 -> pop wins, JMP ignored.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the PC / return-stack block: resolved per-cycle action and sizing helpers.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_pkg;

  // One resolved action per enabled edge, after CALL > RET > JMP > increment priority
  // and after full/empty qualification of CALL/RET.
  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_JMP  = 3'd1,
    PC_CALL = 3'd2,
    PC_RET  = 3'd3,
    PC_OVF  = 3'd4,
    PC_UNF  = 3'd5
  } pc_action_t;

  // Width needed to count 0..depth stack entries inclusive.
  function automatic int lvl_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Decoder <-> PC block bundle: command inputs in, PC and stack status out.
// Latency: n/a (wires only); the PC block registers every output.
// Backpressure: EN=0 stalls the PC block; there is no ready signal back.
interface pc_stack_if
  import pc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = lvl_width(DEPTH);

  logic              EN;
  logic              JMP;
  logic              CALL;
  logic              RET;
  logic [ADDR_W-1:0] JMP_ADDR;
  logic [ADDR_W-1:0] PC_OUT;
  logic [LVL_W-1:0]  STACK_LVL;
  logic              STACK_FULL;
  logic              STACK_EMPTY;
  logic              STACK_ERR;

  // Decoder side: issues commands, observes the PC and stack status.
  modport master (
    output EN, JMP, CALL, RET, JMP_ADDR,
    input  PC_OUT, STACK_LVL, STACK_FULL, STACK_EMPTY, STACK_ERR
  );

  // PC block side.
  modport slave (
    input  EN, JMP, CALL, RET, JMP_ADDR,
    output PC_OUT, STACK_LVL, STACK_FULL, STACK_EMPTY, STACK_ERR
  );

endinterface

// File: rtl/pc_lifo.sv
// Register-array LIFO of return addresses with level count and full/empty decode.
// Latency: push/pop take effect on the next rising edge; top/level are registered state.
// Backpressure: push when full and pop when empty are ignored; the caller flags errors.
module pc_lifo
  import pc_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            top,
  output logic [lvl_width(DEPTH)-1:0] lvl,
  output logic                        full,
  output logic                        empty
);
  localparam int LVL_W = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Push takes precedence if both ever arrive together; the parent never does that.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  assign full  = (lvl == LVL_W'(DEPTH));
  assign empty = (lvl == '0);

  // Storage: write the slot just above the current top; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (lvl == LVL_W'(i))) begin
        mem[i] <= din;
      end
    end
  end

  // Level counter: synchronous active-low reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl <= '0;
    end else if (do_push) begin
      lvl <= lvl + LVL_W'(1);
    end else if (do_pop) begin
      lvl <= lvl - LVL_W'(1);
    end
  end

  // Top-of-stack read mux: the entry just below the level pointer.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lvl == LVL_W'(i + 1)) begin
        top = mem[i];
      end
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with CALL/RET return stack, JMP, increment and sticky stack-error flag.
// Latency: one cycle; a command sampled on edge N is visible on every output after edge N.
// Backpressure: EN=0 freezes PC, stack, level and error flag and ignores all commands.
module pc_stack
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 5,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic         CLK,
  input  logic         RST,
  pc_stack_if.slave    bus
);
  localparam int LVL_W = lvl_width(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] stk_top;
  logic [LVL_W-1:0]  stk_lvl;
  logic              stk_full;
  logic              stk_empty;
  logic              err;
  logic              push;
  logic              pop;
  pc_action_t        action;

  // Return address and plain increment share the same wrap-around adder.
  assign pc_inc = pc + ADDR_W'(1);

  // Priority decode: CALL > RET > JMP > increment, qualified by stack state.
  always_comb begin
    action = PC_INC;
    if (bus.CALL) begin
      action = stk_full ? PC_OVF : PC_CALL;
    end else if (bus.RET) begin
      action = stk_empty ? PC_UNF : PC_RET;
    end else if (bus.JMP) begin
      action = PC_JMP;
    end
  end

  // Next PC per resolved action; overflow/underflow degrade to a plain increment.
  always_comb begin
    pc_next = pc_inc;
    case (action)
      PC_CALL, PC_JMP: pc_next = bus.JMP_ADDR;
      PC_RET:          pc_next = stk_top;
      default:         pc_next = pc_inc;
    endcase
  end

  assign push = bus.EN && (action == PC_CALL);
  assign pop  = bus.EN && (action == PC_RET);

  pc_lifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .lvl   (stk_lvl),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // PC register and sticky error: reset wins over EN and every command.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc  <= RESET_ADDR;
      err <= 1'b0;
    end else if (bus.EN) begin
      pc <= pc_next;
      if ((action == PC_OVF) || (action == PC_UNF)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.PC_OUT      = pc;
  assign bus.STACK_LVL   = stk_lvl;
  assign bus.STACK_FULL  = stk_full;
  assign bus.STACK_EMPTY = stk_empty;
  assign bus.STACK_ERR   = err;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, hand sequences, random vs. model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: EN stalls exercised in the table and randomly.
module tb_pc_stack;
  import pc_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int RA     = 3;
  localparam int MOD    = 1 << ADDR_W;

  logic clk;
  logic rst;

  pc_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  pc_stack #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .RESET_ADDR (ADDR_W'(RA))
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural reference: PC as an integer, stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_err;

  typedef struct {
    string name;
    bit    r;
    bit    en;
    bit    call;
    bit    ret;
    bit    jmp;
    int    addr;
    int    exp_pc;
    int    exp_lvl;
    bit    exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic pc_action_t model_act(input bit call, input bit ret, input bit jmp);
    if (call) return (m_stk.size() == DEPTH) ? PC_OVF : PC_CALL;
    if (ret)  return (m_stk.size() == 0) ? PC_UNF : PC_RET;
    if (jmp)  return PC_JMP;
    return PC_INC;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit call, input bit ret,
                            input bit jmp, input int addr);
    pc_action_t act;
    if (!r) begin
      m_pc = RA;
      m_stk.delete();
      m_err = 1'b0;
    end else if (en) begin
      act = model_act(call, ret, jmp);
      case (act)
        PC_CALL: begin m_stk.push_back((m_pc + 1) % MOD); m_pc = addr; end
        PC_RET:  m_pc = m_stk.pop_back();
        PC_JMP:  m_pc = addr;
        PC_OVF, PC_UNF: begin m_pc = (m_pc + 1) % MOD; m_err = 1'b1; end
        default: m_pc = (m_pc + 1) % MOD;
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle away from the edge.
  task automatic apply(input bit r, input bit en, input bit call, input bit ret,
                       input bit jmp, input int addr);
    rst          = r;
    bus.EN       = en;
    bus.CALL     = call;
    bus.RET      = ret;
    bus.JMP      = jmp;
    bus.JMP_ADDR = ADDR_W'(addr);
    @(posedge clk);
    model_step(r, en, call, ret, jmp, addr);
    #1;
  endtask

  task automatic check(input string name, input int exp_pc, input int exp_lvl, input bit exp_err);
    bit exp_full;
    bit exp_empty;
    exp_full  = (exp_lvl == DEPTH);
    exp_empty = (exp_lvl == 0);
    vectors++;
    if (int'(bus.PC_OUT) != exp_pc || int'(bus.STACK_LVL) != exp_lvl ||
        bus.STACK_FULL != exp_full || bus.STACK_EMPTY != exp_empty || bus.STACK_ERR != exp_err) begin
      miscompares++;
      $display("FAIL %s: got pc=%0d lvl=%0d full=%0b empty=%0b err=%0b, want pc=%0d lvl=%0d full=%0b empty=%0b err=%0b",
               name, bus.PC_OUT, bus.STACK_LVL, bus.STACK_FULL, bus.STACK_EMPTY, bus.STACK_ERR,
               exp_pc, exp_lvl, exp_full, exp_empty, exp_err);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_pc, m_stk.size(), m_err);
  endtask

  function automatic void add(input string name, input bit r, input bit en, input bit call,
                              input bit ret, input bit jmp, input int addr,
                              input int pc, input int lvl, input bit err);
    vec_t v;
    v.name = name; v.r = r; v.en = en; v.call = call; v.ret = ret; v.jmp = jmp;
    v.addr = addr; v.exp_pc = pc; v.exp_lvl = lvl; v.exp_err = err;
    tbl.push_back(v);
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; bus.EN = 1'b0; bus.CALL = 1'b0; bus.RET = 1'b0; bus.JMP = 1'b0; bus.JMP_ADDR = '0;
    m_pc = 0; m_err = 1'b0;

    //   name          r  en cl rt jp addr  pc lvl err
    add("reset",       0, 1, 0, 0, 0,  0,   3, 0, 0);
    add("inc0",        1, 1, 0, 0, 0,  0,   4, 0, 0);
    add("inc1",        1, 1, 0, 0, 0,  0,   5, 0, 0);
    add("inc2",        1, 1, 0, 0, 0,  0,   6, 0, 0);
    add("inc3",        1, 1, 0, 0, 0,  0,   7, 0, 0);
    add("rst_mid",     0, 1, 1, 0, 0, 20,   3, 0, 0);
    add("inc_after",   1, 1, 0, 0, 0,  0,   4, 0, 0);
    add("jmp30",       1, 1, 0, 0, 1, 30,  30, 0, 0);
    add("wrap31",      1, 1, 0, 0, 0,  0,  31, 0, 0);
    add("wrap0",       1, 1, 0, 0, 0,  0,   0, 0, 0);
    add("wrap1",       1, 1, 0, 0, 0,  0,   1, 0, 0);
    add("stall_jmp0",  1, 0, 0, 0, 1, 17,   1, 0, 0);
    add("stall_jmp1",  1, 0, 0, 0, 1, 17,   1, 0, 0);
    add("stall_jmp2",  1, 0, 0, 0, 1, 17,   1, 0, 0);
    add("stall_call",  1, 0, 1, 0, 0, 17,   1, 0, 0);
    add("jmp4",        1, 1, 0, 0, 1,  4,   4, 0, 0);
    add("call20",      1, 1, 1, 0, 0, 20,  20, 1, 0);
    add("sub_inc0",    1, 1, 0, 0, 0,  0,  21, 1, 0);
    add("sub_inc1",    1, 1, 0, 0, 0,  0,  22, 1, 0);
    add("ret_to5",     1, 1, 0, 1, 0,  0,   5, 0, 0);
    add("jmp1",        1, 1, 0, 0, 1,  1,   1, 0, 0);
    add("nest_call1",  1, 1, 1, 0, 0,  2,   2, 1, 0);
    add("nest_call2",  1, 1, 1, 0, 0,  4,   4, 2, 0);
    add("nest_call3",  1, 1, 1, 0, 0,  6,   6, 3, 0);
    add("nest_call4",  1, 1, 1, 0, 0,  8,   8, 4, 0);
    add("full_inc",    1, 1, 0, 0, 0,  0,   9, 4, 0);
    add("overflow",    1, 1, 1, 0, 0, 20,  10, 4, 1);
    add("stall_full",  1, 0, 0, 1, 0,  0,  10, 4, 1);
    add("pop4",        1, 1, 0, 1, 0,  0,   7, 3, 1);
    add("pop3",        1, 1, 0, 1, 0,  0,   5, 2, 1);
    add("pop2",        1, 1, 0, 1, 0,  0,   3, 1, 1);
    add("pop1",        1, 1, 0, 1, 0,  0,   2, 0, 1);
    add("err_held",    1, 1, 0, 0, 0,  0,   3, 0, 1);
    add("rst_clr_err", 0, 0, 0, 0, 0,  0,   3, 0, 0);
    add("jmp0",        1, 1, 0, 0, 1,  0,   0, 0, 0);
    add("underflow",   1, 1, 0, 1, 0,  0,   1, 0, 1);
    add("unf_sticky0", 1, 1, 0, 0, 0,  0,   2, 0, 1);
    add("unf_sticky1", 1, 1, 0, 0, 0,  0,   3, 0, 1);
    add("unf_jmp_ign", 1, 1, 0, 1, 1, 25,   4, 0, 1);
    add("rst_again",   0, 1, 0, 1, 0,  0,   3, 0, 0);
    add("jmp7",        1, 1, 0, 0, 1,  7,   7, 0, 0);
    add("prio_all",    1, 1, 1, 1, 1, 12,  12, 1, 0);
    add("prio_retjmp", 1, 1, 0, 1, 1, 25,   8, 0, 0);
    add("b2b_call",    1, 1, 1, 0, 0, 31,  31, 1, 0);
    add("b2b_ret",     1, 1, 0, 1, 0,  0,   9, 0, 0);
    add("jmp31",       1, 1, 0, 0, 1, 31,  31, 0, 0);
    add("call_wrap",   1, 1, 1, 0, 0, 10,  10, 1, 0);
    add("ret_wrap0",   1, 1, 0, 1, 0,  0,   0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].en, tbl[i].call, tbl[i].ret, tbl[i].jmp, tbl[i].addr);
      check(tbl[i].name, tbl[i].exp_pc, tbl[i].exp_lvl, tbl[i].exp_err);
    end

    // Alternating CALL/RET every cycle from a clean reset.
    apply(0, 1, 0, 0, 0, 0);
    check_model("seq_reset");
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) apply(1, 1, 1, 0, 0, int'($urandom_range(MOD - 1)));
      else            apply(1, 1, 0, 1, 0, 0);
      check_model("seq_callret");
    end

    // Fill the stack, then reset while a CALL is presented on a full stack.
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, 1, 1, 0, 0, 16 + i);
      check_model("seq_fill");
    end
    apply(0, 1, 1, 0, 0, 5);
    check("seq_rst_full", RA, 0, 1'b0);
    apply(1, 1, 0, 1, 0, 0);
    check("seq_unf_after_rst", RA + 1, 0, 1'b1);

    // Random commands against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit r, en, call, ret, jmp;
      r    = ($urandom_range(99) >= 2);
      en   = ($urandom_range(99) < 85);
      call = ($urandom_range(99) < 25);
      ret  = ($urandom_range(99) < 30);
      jmp  = ($urandom_range(99) < 20);
      apply(r, en, call, ret, jmp, int'($urandom_range(MOD - 1)));
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
